// File: rtl/if_stage.sv
// Instruction fetch stage: requests one word at a time from instruction
// memory, holds it for decode, and computes the next PC when decode accepts.
//
// Handshakes:
//   imem side: imem_req/imem_addr are held stable until imem_gnt is seen high.
//              Exactly one request is outstanding; the response arrives via
//              imem_rvalid at least one cycle after the grant. Any rvalid seen
//              while no response is expected is ignored.
//   decode side: inst_valid is high only in HOLD; inst/inst_pc are stable
//              while inst_valid is high and inst_ready is low. A transfer
//              happens on a rising edge where inst_valid && inst_ready.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic [1:0]  npc_op,
   input  logic [31:0] jr_target,
   output logic        addr_err,
   output logic [31:0] fetch_count,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   localparam logic [1:0] NPC_SEQ    = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_JR     = 2'b11;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic        addr_err_q, addr_err_d;

   logic        accept;
   logic [31:0] seq_pc;
   logic [31:0] br_off;
   logic [31:0] npc;
   logic        npc_misaligned;

   assign accept = (state_q == S_HOLD) && inst_ready;

   // Next-PC selection from the held instruction; only used on acceptance.
   always_comb begin
      seq_pc         = inst_pc_q + 32'd4;
      br_off         = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
      npc            = seq_pc;
      npc_misaligned = 1'b0;
      case (npc_op)
         NPC_SEQ:    npc = seq_pc;
         NPC_BRANCH: npc = seq_pc + br_off;
         NPC_JUMP:   npc = {seq_pc[31:28], inst_q[25:0], 2'b00};
         NPC_JR: begin
            // Misaligned register targets are forced to a word boundary.
            npc            = {jr_target[31:2], 2'b00};
            npc_misaligned = (jr_target[1:0] != 2'b00);
         end
         default:    npc = seq_pc;
      endcase
   end

   // FSM next state plus the datapath register updates it controls.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inst_d        = inst_q;
      inst_pc_d     = inst_pc_q;
      fetch_count_d = fetch_count_q;
      addr_err_d    = addr_err_q;
      case (state_q)
         S_REQ: begin
            if (imem_gnt) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               inst_d    = imem_rdata;
               inst_pc_d = pc_q;
               state_d   = S_HOLD;
            end
         end
         S_HOLD: begin
            if (accept) begin
               pc_d          = npc;
               fetch_count_d = fetch_count_q + 32'd1;
               addr_err_d    = addr_err_q | npc_misaligned;
               state_d       = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_PC;
         inst_q        <= 32'd0;
         inst_pc_q     <= 32'd0;
         fetch_count_q <= 32'd0;
         addr_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inst_q        <= inst_d;
         inst_pc_q     <= inst_pc_d;
         fetch_count_q <= fetch_count_d;
         addr_err_q    <= addr_err_d;
      end
   end

   assign imem_req    = (state_q == S_REQ);
   assign imem_addr   = pc_q;
   assign inst        = inst_q;
   assign inst_pc     = inst_pc_q;
   assign inst_valid  = (state_q == S_HOLD);
   assign addr_err    = addr_err_q;
   assign fetch_count = fetch_count_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: lockstep memory/decode driver, reference model of the
// PC sequence, and a monitor that checks each accepted instruction.
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [1:0]  npc_op;
   logic [31:0] jr_target;
   logic        addr_err;
   logic [31:0] fetch_count;
   logic [1:0]  dbg_state;

   int vectors     = 0;
   int miscompares = 0;

   // {inst, inst_pc} expected at each decode acceptance
   logic [63:0] exp_q[$];

   // reference model state
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   logic        m_err;

   if_stage #(.RESET_PC(RESET_PC)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .npc_op     (npc_op),
      .jr_target  (jr_target),
      .addr_err   (addr_err),
      .fetch_count(fetch_count),
      .dbg_state  (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference next-PC rule, written as plain arithmetic.
   function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [31:0] word,
                                           input logic [1:0] op, input logic [31:0] jr);
      int          imm;
      logic [31:0] r;
      imm = int'($signed(word[15:0]));
      case (op)
         2'd0:    r = pc + 32'd4;
         2'd1:    r = pc + 32'd4 + 32'(imm * 4);
         2'd2:    r = ((pc + 32'd4) & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
         default: r = jr & ~32'd3;
      endcase
      return r;
   endfunction

   task automatic check_idle_req(input string tag);
      chk({tag, "_req"},   32'(imem_req), 32'd1);
      chk({tag, "_addr"},  imem_addr, m_pc);
      chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
      chk({tag, "_cnt"},   fetch_count, m_cnt);
      chk({tag, "_err"},   32'(addr_err), 32'(m_err));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst   = 1'b0;
      m_pc  = RESET_PC;
      m_cnt = 32'd0;
      m_err = 1'b0;
   endtask

   // One fetch, entered and left just after a falling edge.
   // abort: 0 none, 1 reset while waiting for data, 2 reset while holding.
   task automatic fetch_one(input logic [31:0] word, input logic [1:0] op, input logic [31:0] jr,
                            input int gd, input int lat, input int hold, input int abort);
      logic [31:0] pc_now;
      pc_now = m_pc;
      check_idle_req("req");
      // grant withheld: address must not move, stray rvalid must do nothing
      for (int i = 0; i < gd; i++) begin
         imem_gnt    = 1'b0;
         imem_rvalid = 1'($urandom_range(0, 1));
         imem_rdata  = $urandom;
         @(negedge clk);
         chk("gnt_wait_req", 32'(imem_req), 32'd1);
         chk("gnt_wait_addr", imem_addr, pc_now);
      end
      imem_rvalid = 1'b0;
      imem_gnt    = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      for (int i = 0; i < lat; i++) begin
         chk("wait_req", 32'(imem_req), 32'd0);
         chk("wait_valid", 32'(inst_valid), 32'd0);
         imem_rdata = $urandom;
         @(negedge clk);
      end
      chk("wait_req", 32'(imem_req), 32'd0);
      if (abort == 1) begin
         do_reset();
         imem_rvalid = 1'b1;           // stale response after reset
         imem_rdata  = $urandom;
         check_idle_req("rst_wait");
         @(negedge clk);
         imem_rvalid = 1'b0;
         check_idle_req("rst_stale");
         return;
      end
      imem_rvalid = 1'b1;
      imem_rdata  = word;
      exp_q.push_back({word, pc_now});
      @(negedge clk);
      imem_rvalid = 1'b0;
      // holding: outputs stable, inputs besides inst_ready are noise
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", 32'(inst_valid), 32'd1);
         chk("hold_req", 32'(imem_req), 32'd0);
         chk("hold_inst", inst, word);
         chk("hold_pc", inst_pc, pc_now);
         chk("hold_cnt", fetch_count, m_cnt);
         imem_rvalid = 1'($urandom_range(0, 1));
         imem_rdata  = $urandom;
         npc_op      = 2'($urandom_range(0, 3));
         jr_target   = $urandom;
         @(negedge clk);
      end
      imem_rvalid = 1'b0;
      if (abort == 2) begin
         do_reset();
         check_idle_req("rst_hold");
         chk("rst_hold_inst", inst, 32'd0);
         return;
      end
      chk("acc_valid", 32'(inst_valid), 32'd1);
      inst_ready = 1'b1;
      npc_op     = op;
      jr_target  = jr;
      m_pc  = ref_npc(pc_now, word, op, jr);
      m_cnt = m_cnt + 32'd1;
      if (op == 2'd3 && jr[1:0] != 2'd0) m_err = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      npc_op     = 2'($urandom_range(0, 3));
      jr_target  = $urandom;
      check_idle_req("next");
   endtask

   // monitor: compare every accepted instruction against the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL accept_unexpected: got inst %h pc %h, expected none", inst, inst_pc);
            end else begin
               logic [63:0] e;
               e = exp_q.pop_front();
               chk("mon_inst", inst, e[63:32]);
               chk("mon_pc", inst_pc, e[31:0]);
            end
         end
      end
   end

   // driver
   initial begin
      rst         = 1'b1;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'd0;
      inst_ready  = 1'b0;
      npc_op      = 2'd0;
      jr_target   = 32'd0;
      @(negedge clk);
      @(negedge clk);
      do_reset();
      check_idle_req("reset");
      chk("reset_inst", inst, 32'd0);
      chk("reset_inst_pc", inst_pc, 32'd0);

      fetch_one(32'h2008_0005, 2'd0, 32'd0,        0, 0, 0, 0); // -> 3004
      fetch_one($urandom,      2'd3, 32'h0000_3010, 1, 1, 1, 0); // -> 3010
      fetch_one(32'h1000_FFFC, 2'd1, $urandom,     0, 0, 0, 0); // beq back -> 3004
      fetch_one($urandom,      2'd3, 32'h0000_3010, 0, 2, 0, 0);
      fetch_one(32'h1000_0003, 2'd1, $urandom,     0, 0, 0, 0); // beq fwd -> 3020
      fetch_one($urandom,      2'd3, 32'h0000_3000, 0, 0, 0, 0);
      fetch_one(32'h0800_0C10, 2'd2, $urandom,     3, 0, 5, 0); // jump -> 3040
      fetch_one($urandom,      2'd3, 32'h0000_3106, 0, 0, 0, 0); // misaligned -> 3104
      fetch_one($urandom,      2'd3, 32'hFFFF_FFFC, 0, 1, 2, 0); // err stays set
      fetch_one($urandom,      2'd0, $urandom,     0, 0, 0, 0); // wrap -> 0
      fetch_one($urandom,      2'd0, $urandom,     0, 1, 0, 1); // reset in WAIT
      fetch_one($urandom,      2'd0, $urandom,     0, 0, 0, 0);
      fetch_one($urandom,      2'd0, $urandom,     1, 0, 2, 2); // reset in HOLD

      for (int n = 0; n < 200; n++) begin
         logic [31:0] jr;
         jr = $urandom;
         if ($urandom_range(0, 3) != 0) jr[1:0] = 2'b00;
         fetch_one($urandom, 2'($urandom_range(0, 3)), jr,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4), 0);
      end

      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
